keypad_emulator: RTL and testbench
==================================

Name: keypad_emulator

Overview:
- Synthesizable 4x4 matrix-keypad model; the passive end of the row-scan interface.
- Observes the one-hot rows driven by the scanner and drives active-low columns as a physical keypad would, including contact bounce on press and release.
- Driven by a command port (key code, hold length), so benches and self-test builds can inject key presses without hardware.

Parameters:
- BOUNCE_CYCLES, 16, length in clk cycles of each bounce window (press and release); 0 disables bounce.
- GAP_CYCLES, 8, minimum fully-open cycles after release before the next command is accepted.
- LFSR_SEED, 8'hA5, non-zero seed for the bounce pattern generator.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- rows  in  4  one-hot active-high row drive; rows[3]=top row, rows[0]=bottom row
- columns  out  4  active-low column sense; columns[3]=leftmost column; 4'b1111 = nothing pressed
- cmd_valid  in  1  press request
- cmd_key  in  4  hex key to press
- cmd_hold  in  16  cycles contact stays solidly closed
- cmd_ready  out  1  high when a command will be accepted
- done  out  1  one-cycle pulse when GAP completes

Behaviour:
- Key map (row top->bottom, column left->right):
  - 1 2 3 A
  - 4 5 6 B
  - 7 8 9 C
  - E 0 F D
- Accepted key's row mask and column mask are registered at accept.
- columns is combinational from rows and the registered contact bit:
  - if contact=1 and (rows & row_mask)!=0, then columns = ~col_mask;
  - otherwise columns = 4'b1111.
  - Multiple rows high: the same rule applies (any overlap closes).
- State machine, with contact value per state:
  - IDLE (contact=0, cmd_ready=1): cmd_valid -> latch key, hold = max(cmd_hold,1), go to BOUNCE_IN (or HELD if BOUNCE_CYCLES=0).
  - BOUNCE_IN (contact = LFSR bit 0, LFSR advances every cycle): stays BOUNCE_CYCLES cycles -> HELD.
  - HELD (contact=1): counts hold cycles -> BOUNCE_OUT (or GAP if BOUNCE_CYCLES=0).
  - BOUNCE_OUT (contact = LFSR bit 0): BOUNCE_CYCLES cycles -> GAP.
  - GAP (contact=0): GAP_CYCLES cycles; done pulses on the final GAP cycle -> IDLE.
- Latency: contact first possible 1 cycle after the accept edge; solid closure starts BOUNCE_CYCLES cycles after accept.
- cmd_ready is 0 in every state except IDLE. cmd_valid while not ready is ignored, not queued.
- LFSR: 8-bit Fibonacci, taps 8,6,5,4. It advances only in bounce states and is never all-zero.
- Counters are 16-bit and saturate-free: each reloads on state entry and counts down to 1.
- Reset (any state, including mid-press): state=IDLE, contact=0, columns=4'b1111, cmd_ready=1 the cycle after, done=0, LFSR=LFSR_SEED, row/col masks=0.
- Reset has priority over a simultaneous cmd_valid.

Decomposition:
- keypad_pkg holds:
  - state typedef (IDLE, BOUNCE_IN, HELD, BOUNCE_OUT, GAP);
  - key_to_row and key_to_col functions returning one-hot 4-bit masks;
  - KEY_IDLE_COLS = 4'b1111.
- One sub-module, bounce_lfsr: clk, reset, en, seed -> 8-bit state. Instantiated once.

Test Plan:
- BOUNCE_CYCLES=0, cmd_key=4'h5, cmd_hold=20, rows cycling 1000/0100/0010/0001 -> columns=4'b1011 only while rows=0100 during HELD; 4'b1111 otherwise; done pulse 20+GAP_CYCLES cycles after accept.
- cmd_key=4'hD, rows held 4'b0001, defaults -> columns toggles between 1111 and 1110 for 16 cycles, solid 1110 for cmd_hold cycles, toggles 16 cycles, then 1111. Toggle sequence matches the golden LFSR model from seed 8'hA5.
- cmd_key=4'h1 with rows fixed at 4'b0100 -> columns stays 4'b1111 throughout the press; done still pulses.
- Second cmd_valid (key 4'h9) issued during HELD of key 4'h2 -> ignored. cmd_ready=0 until GAP ends; only one done pulse; 9 never appears.
- reset asserted during HELD of key 4'hA -> next cycle columns=4'b1111, cmd_ready=1, done=0. A new command afterwards reproduces the identical bounce pattern, since LFSR is reseeded.
- cmd_hold=0, BOUNCE_CYCLES=0, key 4'h0, rows=4'b0001 -> exactly one cycle of columns=4'b1011.

Source files
------------

// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and helpers for the 4x4 keypad emulator.
//   - key_state_e   : press sequencer states
//   - key_to_row/col: one-hot row / column masks for a hex key code
//   - KEY_IDLE_COLS : column sense value when nothing is closed
// Layout (top row first, left column first):
//   1 2 3 A / 4 5 6 B / 7 8 9 C / E 0 F D
// rows[3] is the top row; columns[3] is the leftmost column.
package keypad_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    BOUNCE_IN  = 3'd1,
    HELD       = 3'd2,
    BOUNCE_OUT = 3'd3,
    GAP        = 3'd4
  } key_state_e;

  localparam logic [3:0] KEY_IDLE_COLS = 4'b1111;

  // One-hot row mask (bit 3 = top row) for a key code.
  function automatic logic [3:0] key_to_row(input logic [3:0] key);
    logic [3:0] mask;
    case (key)
      4'h1, 4'h2, 4'h3, 4'hA: mask = 4'b1000;
      4'h4, 4'h5, 4'h6, 4'hB: mask = 4'b0100;
      4'h7, 4'h8, 4'h9, 4'hC: mask = 4'b0010;
      4'hE, 4'h0, 4'hF, 4'hD: mask = 4'b0001;
      default:                mask = 4'b0000;
    endcase
    return mask;
  endfunction

  // One-hot column mask (bit 3 = leftmost column) for a key code.
  function automatic logic [3:0] key_to_col(input logic [3:0] key);
    logic [3:0] mask;
    case (key)
      4'h1, 4'h4, 4'h7, 4'hE: mask = 4'b1000;
      4'h2, 4'h5, 4'h8, 4'h0: mask = 4'b0100;
      4'h3, 4'h6, 4'h9, 4'hF: mask = 4'b0010;
      4'hA, 4'hB, 4'hC, 4'hD: mask = 4'b0001;
      default:                mask = 4'b0000;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/bounce_lfsr.sv
// bounce_lfsr: 8-bit Fibonacci LFSR (taps 8,6,5,4) producing the contact
// bounce pattern.
//   clk   : system clock
//   reset : synchronous active-high; loads seed (0 is replaced by 8'h01)
//   en    : advance one step this cycle
//   seed  : reload value
//   state : current register contents; bit 0 is the bounce contact
module bounce_lfsr (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [7:0] seed,
  output logic [7:0] state
);

  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;

  // Next-state: shift left, feedback from taps 8,6,5,4; a zero register is
  // pushed back onto the sequence so the generator can never lock up.
  always_comb begin
    lfsr_d = lfsr_q;
    if (lfsr_q == 8'h00) begin
      lfsr_d = 8'h01;
    end else if (en) begin
      lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end else begin
      lfsr_d = lfsr_q;
    end
  end

  // State register with seed load on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_q <= (seed == 8'h00) ? 8'h01 : seed;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign state = lfsr_q;

endmodule

// File: rtl/keypad_emulator.sv
// keypad_emulator: passive 4x4 matrix keypad model driven by a command port.
//   clk, reset : system clock, synchronous active-high reset
//   rows       : one-hot active-high row drive from the scanner
//   columns    : active-low column sense (4'b1111 = open)
//   cmd_valid, cmd_key, cmd_hold : press request, key code, solid-hold length
//   cmd_ready  : high only in IDLE; requests while low are dropped
//   done       : one-cycle pulse on the final GAP cycle
// A press runs BOUNCE_IN -> HELD -> BOUNCE_OUT -> GAP; bounce windows are
// skipped when BOUNCE_CYCLES is 0.
module keypad_emulator
  import keypad_pkg::*;
#(
  parameter int unsigned BOUNCE_CYCLES = 16,
  parameter int unsigned GAP_CYCLES    = 8,
  parameter logic [7:0]  LFSR_SEED     = 8'hA5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  rows,
  output logic [3:0]  columns,
  input  logic        cmd_valid,
  input  logic [3:0]  cmd_key,
  input  logic [15:0] cmd_hold,
  output logic        cmd_ready,
  output logic        done
);

  localparam bit          NO_BOUNCE   = (BOUNCE_CYCLES == 32'd0);
  localparam logic [15:0] BOUNCE_LOAD = 16'(BOUNCE_CYCLES);
  // A zero gap would skip the done pulse, so the gap is at least one cycle.
  localparam logic [15:0] GAP_LOAD    = (GAP_CYCLES == 32'd0) ? 16'd1 : 16'(GAP_CYCLES);

  key_state_e  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] hold_q, hold_d;
  logic [3:0]  row_mask_q, row_mask_d;
  logic [3:0]  col_mask_q, col_mask_d;
  logic        ready_q, ready_d;
  logic        done_q, done_d;
  logic [15:0] hold_eff_s;
  logic [7:0]  lfsr_state_s;
  logic        lfsr_en_s;
  logic        contact_s;

  assign hold_eff_s = (cmd_hold == 16'd0) ? 16'd1 : cmd_hold;
  assign lfsr_en_s  = (state_q == BOUNCE_IN) || (state_q == BOUNCE_OUT);

  bounce_lfsr u_bounce_lfsr (
    .clk   (clk),
    .reset (reset),
    .en    (lfsr_en_s),
    .seed  (LFSR_SEED),
    .state (lfsr_state_s)
  );

  // Sequencer next-state; every phase counter reloads on entry and leaves at 1.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    hold_d     = hold_q;
    row_mask_d = row_mask_q;
    col_mask_d = col_mask_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          row_mask_d = key_to_row(cmd_key);
          col_mask_d = key_to_col(cmd_key);
          hold_d     = hold_eff_s;
          if (NO_BOUNCE) begin
            state_d = HELD;
            cnt_d   = hold_eff_s;
          end else begin
            state_d = BOUNCE_IN;
            cnt_d   = BOUNCE_LOAD;
          end
        end else begin
          state_d = IDLE;
        end
      end
      BOUNCE_IN: begin
        if (cnt_q <= 16'd1) begin
          state_d = HELD;
          cnt_d   = hold_q;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      HELD: begin
        if (cnt_q <= 16'd1) begin
          if (NO_BOUNCE) begin
            state_d = GAP;
            cnt_d   = GAP_LOAD;
          end else begin
            state_d = BOUNCE_OUT;
            cnt_d   = BOUNCE_LOAD;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      BOUNCE_OUT: begin
        if (cnt_q <= 16'd1) begin
          state_d = GAP;
          cnt_d   = GAP_LOAD;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      GAP: begin
        if (cnt_q <= 16'd1) begin
          state_d = IDLE;
          cnt_d   = 16'd0;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 16'd0;
      end
    endcase
    // Outputs are registered from the next state so they line up with state_q.
    ready_d = (state_d == IDLE);
    done_d  = (state_d == GAP) && (cnt_d == 16'd1);
  end

  // Contact bit per state; a zero LFSR (upset) is treated as open.
  always_comb begin
    case (state_q)
      BOUNCE_IN, BOUNCE_OUT: contact_s = lfsr_state_s[0] && (lfsr_state_s != 8'h00);
      HELD:                  contact_s = 1'b1;
      default:               contact_s = 1'b0;
    endcase
  end

  // Column sense: any overlap between driven rows and the key's row closes.
  always_comb begin
    if (contact_s && ((rows & row_mask_q) != 4'b0000)) begin
      columns = ~col_mask_q;
    end else begin
      columns = KEY_IDLE_COLS;
    end
  end

  // Sequencer and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= 16'd0;
      hold_q     <= 16'd0;
      row_mask_q <= 4'b0000;
      col_mask_q <= 4'b0000;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hold_q     <= hold_d;
      row_mask_q <= row_mask_d;
      col_mask_q <= col_mask_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
    end
  end

  assign cmd_ready = ready_q;
  assign done      = done_q;

endmodule

// File: tb/tb_keypad_emulator.sv
// Bench for keypad_emulator: two instances (default bounce, and no bounce)
// share one stimulus stream. A press-schedule model predicts every cycle.
module tb_keypad_emulator;

  localparam int         GAP  = 8;
  localparam logic [7:0] SEED = 8'hA5;

  logic        clk = 1'b0;
  logic        reset, cmd_valid;
  logic [3:0]  rows, cmd_key;
  logic [15:0] cmd_hold;
  logic [3:0]  cols_a, cols_b;
  logic        ready_a, ready_b, done_a, done_b;

  always #5 clk = ~clk;

  keypad_emulator #(.BOUNCE_CYCLES(16), .GAP_CYCLES(8), .LFSR_SEED(8'hA5)) dut_a (
    .clk(clk), .reset(reset), .rows(rows), .columns(cols_a), .cmd_valid(cmd_valid),
    .cmd_key(cmd_key), .cmd_hold(cmd_hold), .cmd_ready(ready_a), .done(done_a));

  keypad_emulator #(.BOUNCE_CYCLES(0), .GAP_CYCLES(8), .LFSR_SEED(8'hA5)) dut_b (
    .clk(clk), .reset(reset), .rows(rows), .columns(cols_b), .cmd_valid(cmd_valid),
    .cmd_key(cmd_key), .cmd_hold(cmd_hold), .cmd_ready(ready_b), .done(done_b));

  int n_checks = 0;
  int n_pass   = 0;

  // Model state per instance: a press is a schedule of t = 1..n cycles.
  int         bcyc [2] = '{16, 0};
  bit         m_act  [2];
  int         m_t    [2];
  int         m_n    [2];
  int         m_h    [2];
  logic [63:0] m_bits [2];
  logic [7:0] m_lfsr [2];
  logic [3:0] m_row  [2];
  logic [3:0] m_col  [2];

  logic [3:0] layout [16] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                              4'h7, 4'h8, 4'h9, 4'hC, 4'hE, 4'h0, 4'hF, 4'hD};

  typedef struct { logic [3:0] key; logic [3:0] rows; logic [3:0] cols; } vec_t;
  vec_t tbl [12];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic int key_pos(input logic [3:0] k);
    for (int p = 0; p < 16; p++) if (layout[p] == k) return p;
    return 0;
  endfunction

  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        m_act[i]  = 1'b0;
        m_lfsr[i] = SEED;
      end else if (m_act[i]) begin
        if (m_t[i] == m_n[i]) m_act[i] = 1'b0;
        else m_t[i]++;
      end else if (cmd_valid) begin
        int p;
        p = key_pos(cmd_key);
        m_row[i] = 4'b1000 >> (p / 4);
        m_col[i] = 4'b1000 >> (p % 4);
        m_h[i]   = (cmd_hold == 16'd0) ? 1 : int'(cmd_hold);
        for (int k = 0; k < 2 * bcyc[i]; k++) begin
          m_bits[i][k] = m_lfsr[i][0];
          m_lfsr[i]    = lfsr_next(m_lfsr[i]);
        end
        m_n[i]   = 2 * bcyc[i] + m_h[i] + GAP;
        m_t[i]   = 1;
        m_act[i] = 1'b1;
      end
    end
  endtask

  function automatic bit exp_contact(input int i);
    int t, b, h;
    t = m_t[i]; b = bcyc[i]; h = m_h[i];
    if (!m_act[i]) return 1'b0;
    if (t <= b) return m_bits[i][t-1];
    if (t <= b + h) return 1'b1;
    if (t <= 2 * b + h) return m_bits[i][t-h-1];
    return 1'b0;
  endfunction

  function automatic logic [3:0] exp_cols(input int i);
    if (exp_contact(i) && ((rows & m_row[i]) != 4'b0000)) return ~m_col[i];
    return 4'b1111;
  endfunction

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("cols_a",  {12'd0, cols_a}, {12'd0, exp_cols(0)});
    check("cols_b",  {12'd0, cols_b}, {12'd0, exp_cols(1)});
    check("ready_a", {15'd0, ready_a}, {15'd0, !m_act[0]});
    check("ready_b", {15'd0, ready_b}, {15'd0, !m_act[1]});
    check("done_a",  {15'd0, done_a}, {15'd0, (m_act[0] && m_t[0] == m_n[0])});
    check("done_b",  {15'd0, done_b}, {15'd0, (m_act[1] && m_t[1] == m_n[1])});
  endtask

  task automatic press(input logic [3:0] key, input logic [15:0] hold);
    cmd_key = key; cmd_hold = hold; cmd_valid = 1'b1;
    cycle();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 300; i++) begin
      if (ready_a && ready_b) break;
      cycle();
    end
    check("wait_ready_bound", {15'd0, ready_a && ready_b}, 16'd1);
  endtask

  initial begin
    int done_at, hits, dones, nine;
    logic [7:0] s;
    tbl[0]  = '{4'h5, 4'b0100, 4'b1011};
    tbl[1]  = '{4'h5, 4'b1000, 4'b1111};
    tbl[2]  = '{4'hD, 4'b0001, 4'b1110};
    tbl[3]  = '{4'h1, 4'b0100, 4'b1111};
    tbl[4]  = '{4'h1, 4'b1000, 4'b0111};
    tbl[5]  = '{4'hA, 4'b1000, 4'b1110};
    tbl[6]  = '{4'hE, 4'b0001, 4'b0111};
    tbl[7]  = '{4'h0, 4'b0011, 4'b1011};
    tbl[8]  = '{4'hF, 4'b1111, 4'b1101};
    tbl[9]  = '{4'h9, 4'b0010, 4'b1101};
    tbl[10] = '{4'hC, 4'b0010, 4'b1110};
    tbl[11] = '{4'h2, 4'b0000, 4'b1111};
    for (int i = 0; i < 2; i++) begin m_act[i] = 1'b0; m_lfsr[i] = SEED; end
    reset = 1'b1; cmd_valid = 1'b0; rows = 4'b0000; cmd_key = 4'h0; cmd_hold = 16'd0;
    @(negedge clk);
    cycle(); cycle();
    check("rst_cols_a", {12'd0, cols_a}, 16'h000F);
    check("rst_cols_b", {12'd0, cols_b}, 16'h000F);
    check("rst_ready_a", {15'd0, ready_a}, 16'd1);
    check("rst_done_a", {15'd0, done_a}, 16'd0);
    reset = 1'b0;
    cycle();

    // Key 5, no bounce, rotating rows: closes only on the middle-upper row.
    wait_ready();
    done_at = -1; hits = 0;
    rows = 4'b0100; press(4'h5, 16'd20);
    for (int k = 1; k <= 60; k++) begin
      if (k > 1) begin rows = 4'b1000 >> (k % 4); cycle(); end
      if (done_b && done_at < 0) done_at = k;
      if (cols_b == 4'b1011) hits++;
    end
    check("b_done_latency", 16'(done_at), 16'd28);
    check("b_hold_hits", 16'(hits), 16'd5);

    // Key D with bounce: done after 16 + hold + 16 + gap.
    wait_ready();
    done_at = -1; rows = 4'b0001; press(4'hD, 16'd10);
    for (int k = 2; k <= 60; k++) begin
      cycle();
      if (done_a && done_at < 0) done_at = k;
    end
    check("a_done_latency", 16'(done_at), 16'd50);

    // Key 1 scanned on the wrong row: never closes, still completes.
    wait_ready();
    hits = 0; dones = 0; rows = 4'b0100; press(4'h1, 16'd12);
    for (int k = 2; k <= 70; k++) begin
      cycle();
      if (cols_a != 4'b1111 || cols_b != 4'b1111) hits++;
      if (done_a) dones++;
    end
    check("wrong_row_cols", 16'(hits), 16'd0);
    check("wrong_row_done", 16'(dones), 16'd1);

    // Second request during HELD is dropped.
    wait_ready();
    dones = 0; nine = 0; rows = 4'b1010; press(4'h2, 16'd30);
    for (int k = 2; k <= 80; k++) begin
      cmd_valid = (k >= 20 && k <= 22); cmd_key = 4'h9; cmd_hold = 16'd5;
      cycle();
      if (k == 20) check("busy_ready_a", {15'd0, ready_a}, 16'd0);
      if (cols_a == 4'b1101 || cols_b == 4'b1101) nine++;
      if (done_a) dones++;
    end
    cmd_valid = 1'b0;
    check("ignored_key9", 16'(nine), 16'd0);
    check("single_done", 16'(dones), 16'd1);

    // Reset mid-HELD, then the bounce pattern restarts from the seed.
    reset = 1'b1; cycle(); reset = 1'b0;
    rows = 4'b1000; press(4'hA, 16'd40);
    for (int k = 2; k <= 25; k++) cycle();
    reset = 1'b1; cycle(); reset = 1'b0;
    check("midreset_cols", {12'd0, cols_a}, 16'h000F);
    check("midreset_ready", {15'd0, ready_a}, 16'd1);
    check("midreset_done", {15'd0, done_a}, 16'd0);
    s = SEED;
    press(4'hA, 16'd6);
    for (int k = 1; k <= 16; k++) begin
      if (k > 1) cycle();
      check("reseed_bounce", {12'd0, cols_a}, s[0] ? 16'h000E : 16'h000F);
      s = lfsr_next(s);
    end

    // Zero hold, no bounce: exactly one closed cycle.
    wait_ready();
    hits = 0; done_at = -1; rows = 4'b0001; press(4'h0, 16'd0);
    for (int k = 1; k <= 20; k++) begin
      if (k > 1) cycle();
      if (cols_b == 4'b1011) hits++;
      if (done_b && done_at < 0) done_at = k;
    end
    check("hold0_closed", 16'(hits), 16'd1);
    check("hold0_done", 16'(done_at), 16'd9);

    // Key map table on the no-bounce instance (first HELD cycle).
    foreach (tbl[i]) begin
      wait_ready();
      rows = tbl[i].rows;
      press(tbl[i].key, 16'd4);
      check("table_cols", {12'd0, cols_b}, {12'd0, tbl[i].cols});
    end

    // Random traffic against the model.
    for (int k = 0; k < 800; k++) begin
      reset     = ($urandom_range(0, 63) == 0);
      cmd_valid = ($urandom_range(0, 3) == 0);
      cmd_key   = 4'($urandom);
      cmd_hold  = 16'($urandom_range(0, 8));
      rows      = 4'($urandom);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
